// File: rtl/hilo_md_unit.sv
// Multiply/divide unit with HI/LO registers for the E stage.
// One operation runs at a time, and its result is committed after a fixed, per-class latency.
module hilo_md_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             req,
  output logic             busy,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  typedef struct packed {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
  } hilo_t;

  state_e          state;
  logic [CW-1:0]   cnt;
  hilo_t           pend;

  logic            is_mul, is_div, is_start, accept;
  logic            mul_sgn, div_sgn;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod, acc;
  hilo_t           mul_res, div_res;
  logic            a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, b_safe, q_mag, r_mag;

  always_comb begin
    is_mul   = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
               (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
    is_div   = (op == OP_DIV) || (op == OP_DIVU);
    is_start = is_mul || is_div;
    accept   = is_start && !req && (state == S_IDLE);
    busy     = (state == S_RUN) || (is_start && !req);
  end

  // Sign-extending to 2*WIDTH lets one truncated multiplier serve both signed and unsigned ops.
  always_comb begin
    mul_sgn = (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
    a_ext   = {{WIDTH{mul_sgn & rs[WIDTH-1]}}, rs};
    b_ext   = {{WIDTH{mul_sgn & rt[WIDTH-1]}}, rt};
    prod    = a_ext * b_ext;
    acc     = {hi, lo};
    case (op)
      OP_MADD, OP_MADDU: mul_res = acc + prod;
      OP_MSUB, OP_MSUBU: mul_res = acc - prod;
      default:           mul_res = prod;
    endcase
  end

  // Signed divide runs on magnitudes; quotient/remainder signs are restored afterwards.
  always_comb begin
    div_sgn = (op == OP_DIV);
    a_neg   = div_sgn & rs[WIDTH-1];
    b_neg   = div_sgn & rt[WIDTH-1];
    a_mag   = a_neg ? -rs : rs;
    b_mag   = b_neg ? -rt : rt;
    b_safe  = (b_mag == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    q_mag   = a_mag / b_safe;
    r_mag   = a_mag % b_safe;
    if (rt == '0) begin
      div_res.hi = rs;
      div_res.lo = '1;
    end else if (div_sgn && rs == {1'b1, {(WIDTH-1){1'b0}}} && rt == '1) begin
      div_res.hi = '0;
      div_res.lo = rs;
    end else begin
      div_res.hi = a_neg ? -r_mag : r_mag;
      div_res.lo = (a_neg ^ b_neg) ? -q_mag : q_mag;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      pend  <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            pend  <= is_div ? div_res : mul_res;
            cnt   <= is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
            state <= S_RUN;
          end else if (!req && op == OP_MTHI) begin
            hi <= rs;
          end else if (!req && op == OP_MTLO) begin
            lo <= rs;
          end
        end
        default: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            hi    <= pend.hi;
            lo    <= pend.lo;
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    out = '0;
    if (op == OP_MFHI)      out = hi;
    else if (op == OP_MFLO) out = lo;
  end

endmodule

// File: tb/tb_hilo_md_unit.sv
// Self-checking bench for hilo_md_unit: directed test-plan steps followed by randomized ops,
// all checked against an arithmetic reference model.
module tb_hilo_md_unit;
  localparam int W     = 32;
  localparam int MUL_C = 5;
  localparam int DIV_C = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   op;
  logic [W-1:0] rs, rt;
  logic         req;
  logic         busy;
  logic [W-1:0] out, hi, lo;

  int nvec = 0;
  int nmis = 0;
  logic [W-1:0] m_hi, m_lo;

  hilo_md_unit #(.WIDTH(W), .MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
    .clk(clk), .reset(reset), .op(op), .rs(rs), .rt(rt), .req(req),
    .busy(busy), .out(out), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_start(input logic [3:0] o);
    return (o >= 4'd1 && o <= 4'd4) || (o >= 4'd9 && o <= 4'd12);
  endfunction

  // Returns {HI,LO} after the operation, from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] h,
                                        input logic [31:0] l);
    longint          sp;
    longint unsigned ua, ub, up, ac;
    int              sa, sb, q, r;
    sa = $signed(a);
    sb = $signed(b);
    sp = longint'(sa) * longint'(sb);
    ua = a;
    ub = b;
    up = ua * ub;
    ac = {h, l};
    case (o)
      4'd1:  return 64'(sp);
      4'd2:  return up;
      4'd9:  return ac + 64'(sp);
      4'd10: return ac + up;
      4'd11: return ac - 64'(sp);
      4'd12: return ac - up;
      4'd3: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, a};
        q = sa / sb;
        r = sa % sb;
        return {32'(r), 32'(q)};
      end
      4'd4: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      default: return {h, l};
    endcase
  endfunction

  // Start-class op with full latency check; a disturbing op/req is driven in RUN cycle 2.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] dop, input logic dreq);
    logic [63:0] e;
    int n;
    e = model(o, a, b, m_hi, m_lo);
    n = (o == 4'd3 || o == 4'd4) ? DIV_C : MUL_C;
    @(negedge clk);
    op = o; rs = a; rt = b; req = 1'b0;
    #1 chk("busy_accept", busy, 1);
    @(negedge clk);
    for (int c = 1; c <= n; c++) begin
      if (c == 2) begin
        op = dop; req = dreq; rs = $urandom; rt = $urandom;
      end else begin
        op = 4'd0; req = 1'b0;
      end
      #1;
      chk("busy_run", busy, 1);
      chk("hi_hold", hi, m_hi);
      chk("lo_hold", lo, m_lo);
      @(negedge clk);
    end
    op = 4'd0; req = 1'b0;
    #1;
    chk("busy_done", busy, 0);
    chk("hi_commit", hi, e[63:32]);
    chk("lo_commit", lo, e[31:0]);
    m_hi = e[63:32];
    m_lo = e[31:0];
  endtask

  // Single-cycle op (MT/MF/NONE, or a start op blocked by req).
  task automatic simple_op(input logic [3:0] o, input logic [31:0] a, input logic r);
    logic [31:0] eo;
    eo = (o == 4'd7) ? m_hi : (o == 4'd8) ? m_lo : 32'h0;
    @(negedge clk);
    op = o; rs = a; rt = $urandom; req = r;
    #1;
    chk("busy_simple", busy, (is_start(o) && !r) ? 1 : 0);
    chk("out", out, eo);
    if (!r && o == 4'd5) m_hi = a;
    if (!r && o == 4'd6) m_lo = a;
    @(negedge clk);
    op = 4'd0; req = 1'b0;
    #1;
    chk("hi_simple", hi, m_hi);
    chk("lo_simple", lo, m_lo);
  endtask

  initial begin
    logic [3:0]  ro;
    logic [31:0] ra, rb;
    logic        rr;
    reset = 1'b0; op = 4'd0; rs = '0; rt = '0; req = 1'b0;
    m_hi = '0; m_lo = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_out", out, 0);
    @(negedge clk) reset = 1'b1;

    run_op(4'd1, 32'hFFFFFFFD, 32'd7, 4'd0, 1'b0);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFEB);
    simple_op(4'd8, 32'h0, 1'b0);

    run_op(4'd4, 32'd100, 32'd7, 4'd0, 1'b0);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    run_op(4'd3, 32'hFFFFFFF9, 32'd2, 4'd0, 1'b0);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    run_op(4'd3, 32'd5, 32'd0, 4'd0, 1'b0);
    chk("div0_hi", hi, 32'd5);
    chk("div0_lo", lo, 32'hFFFFFFFF);
    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 4'd0, 1'b0);
    chk("ovf_lo", lo, 32'h80000000);
    chk("ovf_hi", hi, 32'h0);

    simple_op(4'd5, 32'h0, 1'b0);
    simple_op(4'd6, 32'hFFFFFFFF, 1'b0);
    run_op(4'd10, 32'd1, 32'd1, 4'd0, 1'b0);
    chk("maddu_hi", hi, 32'd1);
    chk("maddu_lo", lo, 32'd0);
    simple_op(4'd5, 32'h0, 1'b0);
    simple_op(4'd6, 32'h0, 1'b0);
    run_op(4'd11, 32'd2, 32'd3, 4'd0, 1'b0);
    chk("msub_hi", hi, 32'hFFFFFFFF);
    chk("msub_lo", lo, 32'hFFFFFFFA);

    simple_op(4'd1, 32'h12345678, 1'b1);
    simple_op(4'd6, 32'hDEADBEEF, 1'b1);
    run_op(4'd1, 32'd9, 32'd11, 4'd0, 1'b1);
    run_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd3, 1'b0);
    run_op(4'd4, 32'd77, 32'd5, 4'd5, 1'b0);
    simple_op(4'd7, 32'h0, 1'b0);

    // Reset in the middle of a divide must clear everything without a clock edge.
    simple_op(4'd5, 32'h1234, 1'b0);
    simple_op(4'd6, 32'h5678, 1'b0);
    @(negedge clk);
    op = 4'd3; rs = 32'd1000; rt = 32'd3; req = 1'b0;
    @(negedge clk) op = 4'd0;
    @(negedge clk);
    @(negedge clk);
    #1 chk("pre_rst_busy", busy, 1);
    #1 reset = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    m_hi = '0; m_lo = '0;
    @(negedge clk) reset = 1'b1;
    run_op(4'd2, 32'd3, 32'd4, 4'd0, 1'b0);
    chk("multu_lo", lo, 32'd12);
    chk("multu_hi", hi, 32'd0);

    for (int i = 0; i < 60; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = 32'($urandom_range(1, 9));
        default: ;
      endcase
      rr = ($urandom_range(0, 4) == 0);
      if (is_start(ro) && !rr) run_op(ro, ra, rb, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      else simple_op(ro, ra, rr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
